// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller driving a 16x64 true-dual-port RAM (port A write, port B read)
// with a 2-entry output buffer hiding the read latency. Optional flush port via FIFO_FLUSH_EN.
module ram_fifo_ctrl #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_afull,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] level,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_address_a,
  output logic              ram_wren_a,
  output logic              ram_rden_a,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic [ADDR_W-1:0] ram_address_b,
  output logic              ram_rden_b,
  output logic              ram_wren_b,
  output logic [DATA_W-1:0] ram_data_b
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);

  logic              flushW;
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        obPending;
  logic              obTail;

  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   ramCount_q, ramCount_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        obCount_q, obCount_d;
  logic              obHead_q, obHead_d;
  logic [DATA_W-1:0] obMem_q [2];
  logic [DATA_W-1:0] obMem_d [2];

`ifdef FIFO_FLUSH_EN
  assign flushW = flush;
`else
  assign flushW = 1'b0;
`endif

  // reset_n in the push term makes the write strobe drop as soon as reset asserts
  always_comb begin
    s_ready   = (ramCount_q != DEPTH_C);
    m_valid   = (obCount_q != 2'd0);
    push      = s_valid & s_ready & reset_n & ~flushW;
    pop       = m_valid & m_ready & ~flushW;
    obPending = {1'b0, obCount_q} + {2'b00, inflight_q} - {2'b00, m_valid & m_ready};
    issue     = (ramCount_q != '0) & (obPending < 3'd2) & ~flushW;
    obTail    = obHead_q ^ (obCount_q != 2'd0);
  end

  always_comb begin
    s_afull       = (ramCount_q >= AFULL_C);
    m_data        = obMem_q[obHead_q];
    level         = {1'b0, ramCount_q} + (ADDR_W+2)'(inflight_q) + (ADDR_W+2)'(obCount_q);
    ram_data_a    = s_data;
    ram_address_a = wrPtr_q;
    ram_wren_a    = push;
    ram_rden_a    = 1'b0;
    ram_address_b = rdPtr_q;
    ram_rden_b    = issue;
    ram_wren_b    = 1'b0;
    ram_data_b    = '0;
  end

  // Capture into the buffer tail never collides with a full buffer: issue keeps ob+inflight <= 2
  always_comb begin
    wrPtr_d    = wrPtr_q + ADDR_W'(push);
    rdPtr_d    = rdPtr_q + ADDR_W'(issue);
    ramCount_d = ramCount_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
    inflight_d = issue;
    obCount_d  = obCount_q + 2'(inflight_q) - 2'(pop);
    obHead_d   = obHead_q ^ pop;
    obMem_d[0] = obMem_q[0];
    obMem_d[1] = obMem_q[1];
    if (inflight_q) obMem_d[obTail] = ram_q_b;
    if (flushW) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      ramCount_d = '0;
      inflight_d = 1'b0;
      obCount_d  = 2'd0;
      obHead_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      ramCount_q <= '0;
      inflight_q <= 1'b0;
      obCount_q  <= 2'd0;
      obHead_q   <= 1'b0;
      obMem_q[0] <= '0;
      obMem_q[1] <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      ramCount_q <= ramCount_d;
      inflight_q <= inflight_d;
      obCount_q  <= obCount_d;
      obHead_q   <= obHead_d;
      obMem_q[0] <= obMem_d[0];
      obMem_q[1] <= obMem_d[1];
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM model, scoreboard queue
// filled at accepted pushes and drained by a monitor at every observed pop.
module tb_ram_fifo_ctrl;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 4;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              flush = 1'b0;
   logic              s_valid, s_ready, s_afull;
   logic [DATA_W-1:0] s_data;
   logic              m_valid, m_ready;
   logic [DATA_W-1:0] m_data;
   logic [ADDR_W+1:0] level;
   logic [DATA_W-1:0] ram_data_a, ram_data_b;
   logic [DATA_W-1:0] ram_q_b = '0;
   logic [ADDR_W-1:0] ram_address_a, ram_address_b;
   logic              ram_wren_a, ram_rden_a, ram_rden_b, ram_wren_b;

   logic [DATA_W-1:0] ramMem [16];
   logic [DATA_W-1:0] expQ [$];
   int                testCount  = 0;
   int                errorCount = 0;
   int                modelLevel = 0;
   int                popCount   = 0;

   always #5 clock = ~clock;

   ram_fifo_ctrl dut (
      .clock         (clock),
      .reset_n       (reset_n),
`ifdef FIFO_FLUSH_EN
      .flush         (flush),
`endif
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_afull       (s_afull),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .level         (level),
      .ram_data_a    (ram_data_a),
      .ram_address_a (ram_address_a),
      .ram_wren_a    (ram_wren_a),
      .ram_rden_a    (ram_rden_a),
      .ram_q_b       (ram_q_b),
      .ram_address_b (ram_address_b),
      .ram_rden_b    (ram_rden_b),
      .ram_wren_b    (ram_wren_b),
      .ram_data_b    (ram_data_b)
   );

   // Behavioural dual-port RAM with one cycle of read latency on port B
   always @(posedge clock) begin
      if (ram_wren_a) ramMem[ram_address_a] <= ram_data_a;
      if (ram_rden_b) ramMem[ram_address_b] <= ramMem[ram_address_b];
      if (ram_rden_b) ram_q_b <= ramMem[ram_address_b];
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r);
      s_valid = v;
      s_data  = d;
      m_ready = r;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      applyStimulus(1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 60 && level != 0; i++) step();
      checkOutput("drain_empty", 64'(level), 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b0);
   endtask

   // Monitor: level tracks the model, every pop is checked against the scoreboard head
   always @(negedge clock) begin
      if (!reset_n || flush) begin
         expQ.delete();
         modelLevel = 0;
      end else begin
         checkOutput("level", 64'(level), 64'(modelLevel));
         if (modelLevel < 16)  checkOutput("s_ready_free", 64'(s_ready), 64'd1);
         if (modelLevel == 18) checkOutput("s_ready_full", 64'(s_ready), 64'd0);
         if (m_valid && m_ready) begin
            if (expQ.size() == 0) begin
               testCount++;
               errorCount++;
               $display("[TB] FAIL pop_unexpected: got %0h expected no word", m_data);
            end else begin
               checkOutput("m_data", m_data, expQ.pop_front());
            end
            modelLevel--;
            popCount++;
         end
         if (s_valid && s_ready) begin
            expQ.push_back(s_data);
            modelLevel++;
         end
      end
   end

   // Directed sequences: reset, single word latency, fill/drain, streaming, random, reset mid-stream
   initial begin
      reset_n = 1'b0;
      applyStimulus(1'b0, 64'd0, 1'b0);
      step();
      step();
      checkOutput("rst_s_ready", 64'(s_ready), 64'd1);
      checkOutput("rst_s_afull", 64'(s_afull), 64'd0);
      checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_m_data", m_data, 64'd0);
      checkOutput("rst_level", 64'(level), 64'd0);
      checkOutput("rst_strobes", 64'({ram_wren_a, ram_rden_a, ram_rden_b, ram_wren_b}), 64'd0);
      reset_n = 1'b1;
      step();

      applyStimulus(1'b1, 64'hA5, 1'b0);
      step();
      applyStimulus(1'b0, 64'd0, 1'b0);
      checkOutput("single_rden", 64'(ram_rden_b), 64'd1);
      checkOutput("single_mv_n1", 64'(m_valid), 64'd0);
      step();
      checkOutput("single_mv_n2", 64'(m_valid), 64'd0);
      step();
      checkOutput("single_mv", 64'(m_valid), 64'd1);
      checkOutput("single_data", m_data, 64'hA5);
      applyStimulus(1'b0, 64'd0, 1'b1);
      step();
      applyStimulus(1'b0, 64'd0, 1'b0);
      checkOutput("single_level", 64'(level), 64'd0);

      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b1, 64'(i), 1'b0);
         step();
      end
      applyStimulus(1'b0, 64'd0, 1'b0);
      checkOutput("fill_s_ready", 64'(s_ready), 64'd0);
      checkOutput("fill_level", 64'(level), 64'd18);
      checkOutput("fill_afull", 64'(s_afull), 64'd1);
      applyStimulus(1'b1, 64'd99, 1'b0);
      step();
      applyStimulus(1'b0, 64'd0, 1'b0);
      checkOutput("fill_refused", 64'(level), 64'd18);
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b0, 64'd0, 1'b1);
         checkOutput("drain_no_bubble", 64'(m_valid), 64'd1);
         checkOutput("drain_order", m_data, 64'(i));
         step();
      end
      applyStimulus(1'b0, 64'd0, 1'b0);
      checkOutput("drain_level", 64'(level), 64'd0);

      popCount = 0;
      for (int k = 0; k < 100; k++) begin
         applyStimulus(1'b1, 64'(1000 + k), 1'b1);
         step();
      end
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("stream_rate", 64'(popCount), 64'd97);
      drain();

      for (int k = 0; k < 2000; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
         step();
      end
      drain();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 64'(200 + i), 1'b0);
         step();
      end
      applyStimulus(1'b1, 64'h55, 1'b0);
      checkOutput("pre_reset_level", 64'(level), 64'd9);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_level", 64'(level), 64'd0);
      checkOutput("midrst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("midrst_wren", 64'(ram_wren_a), 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b0);
      step();
      reset_n = 1'b1;
      step();
      applyStimulus(1'b1, 64'h1, 1'b0);
      step();
      applyStimulus(1'b0, 64'd0, 1'b0);
      step();
      step();
      checkOutput("post_rst_mv", 64'(m_valid), 64'd1);
      checkOutput("post_rst_data", m_data, 64'h1);
      drain();

`ifdef FIFO_FLUSH_EN
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 64'(300 + i), 1'b0);
         step();
      end
      applyStimulus(1'b1, 64'h66, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      applyStimulus(1'b0, 64'd0, 1'b0);
      checkOutput("flush_level", 64'(level), 64'd0);
      checkOutput("flush_m_valid", 64'(m_valid), 64'd0);
      step();
      applyStimulus(1'b1, 64'h2, 1'b0);
      step();
      applyStimulus(1'b0, 64'd0, 1'b0);
      step();
      step();
      checkOutput("post_flush_data", m_data, 64'h2);
      drain();
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", testCount, errorCount);
      $finish;
   end

endmodule
